gcd_engine: RTL and testbench

//  Parametrised multi-cycle GCD unit using subtractive Euclid, with valid/ready handshakes on input and output.

---
 rtl/gcd_pkg.sv | 14 +
 rtl/gcd_step.sv | 35 +++
 rtl/gcd_engine.sv | 154 +++++++++++++++
 tb/tb_gcd_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default operand width for the GCD engine.
package gcd_pkg;

  // Default operand/result width
  localparam int GCD_WIDTH_DEF = 5;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_step.sv
// gcd_step: one combinational step of subtractive Euclid.
// When either operand is zero the step reports completion and the gcd
// (a|b covers gcd(0,b)=b, gcd(a,0)=a and gcd(0,0)=0). Otherwise the larger
// operand is reduced by the smaller; the compare guards the subtraction so it
// never underflows.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] next_a_o,
  output logic [WIDTH-1:0] next_b_o,
  output logic             zero_hit_o,
  output logic [WIDTH-1:0] gcd_val_o
);

  // Compare/subtract datapath for a single Euclid iteration
  always_comb begin
    next_a_o   = a_i;
    next_b_o   = b_i;
    zero_hit_o = (a_i == {WIDTH{1'b0}}) || (b_i == {WIDTH{1'b0}});
    gcd_val_o  = a_i | b_i;
    if (zero_hit_o) begin
      next_a_o = a_i;
      next_b_o = b_i;
    end else if (a_i >= b_i) begin
      next_a_o = a_i - b_i;
    end else begin
      next_b_o = b_i - a_i;
    end
  end

endmodule : gcd_step

// File: rtl/gcd_engine.sv
// gcd_engine: multi-cycle subtractive-Euclid GCD with valid/ready handshakes.
// IDLE accepts operands, CALC runs one gcd_step per cycle, DONE holds the
// result until the consumer takes it. clear is a synchronous abort with
// priority over every transition; reset is asynchronous, active-high.
// Optional feature: define GCD_CYCLE_COUNT_EN to add the 'cycles' port, a
// saturating count of CALC cycles for the last/current job.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  // Reject configurations the datapath and counter cannot represent
  if (WIDTH < 2) begin : g_bad_width
    $error("gcd_engine: WIDTH must be at least 2");
  end
  if (CNT_W < WIDTH + 1) begin : g_bad_cnt_w
    $error("gcd_engine: CNT_W must hold 2**WIDTH");
  end

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] step_a_s;
  logic [WIDTH-1:0] step_b_s;
  logic             step_zero_s;
  logic [WIDTH-1:0] step_gcd_s;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i        (a_q),
    .b_i        (b_q),
    .next_a_o   (step_a_s),
    .next_b_o   (step_b_s),
    .zero_hit_o (step_zero_s),
    .gcd_val_o  (step_gcd_s)
  );

  // Next-state and datapath update; clear overrides every transition
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (clear) begin
      state_d  = ST_IDLE;
      a_d      = {WIDTH{1'b0}};
      b_d      = {WIDTH{1'b0}};
      result_d = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_d     = a_in;
            b_d     = b_in;
            state_d = ST_CALC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (step_zero_s) begin
            result_d = step_gcd_s;
            state_d  = ST_DONE;
          end else begin
            a_d = step_a_s;
            b_d = step_b_s;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, operand and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Handshake and status flags decode straight from the state register
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign result    = result_q;

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycle counter: zeroed on capture, +1 per CALC cycle, sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_IDLE) && in_valid) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_CALC) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycles = cnt_q;
`endif

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed-vector bench for gcd_engine (WIDTH=5 and WIDTH=8).
// Expected results and CALC-cycle counts are hand-computed from subtractive
// Euclid: N = number of subtractions + 1.
module tb_gcd_engine;

  logic clk;
  logic reset;
  logic clear;

  // WIDTH=5 instance signals
  logic       iv5, ir5, ov5, or5, busy5;
  logic [4:0] a5, b5, res5;
  // WIDTH=8 instance signals
  logic       iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, b8, res8;
`ifdef GCD_CYCLE_COUNT_EN
  logic [5:0] cyc5;
  logic [8:0] cyc8;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cur_sel = 0;

  gcd_engine #(.WIDTH(5)) dut5 (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (iv5),
    .in_ready  (ir5),
    .a_in      (a5),
    .b_in      (b5),
    .out_valid (ov5),
    .out_ready (or5),
    .result    (res5),
    .busy      (busy5)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cyc5)
`endif
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a_in      (a8),
    .b_in      (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .result    (res8),
    .busy      (busy8)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cyc8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Views of whichever instance the current job targets
  logic       ov_m, ir_m, busy_m;
  logic [7:0] res_m;
  assign ov_m   = (cur_sel == 1) ? ov8   : ov5;
  assign ir_m   = (cur_sel == 1) ? ir8   : ir5;
  assign busy_m = (cur_sel == 1) ? busy8 : busy5;
  assign res_m  = (cur_sel == 1) ? res8  : {3'b000, res5};
`ifdef GCD_CYCLE_COUNT_EN
  logic [8:0] cyc_m;
  assign cyc_m  = (cur_sel == 1) ? cyc8 : {3'b000, cyc5};
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) iv8 = v;
    else          iv5 = v;
  endtask

  // Present operands at a falling edge; return just after the capture edge
  task automatic start_job(input int sel, input int a, input int b);
    cur_sel = sel;
    @(negedge clk);
    if (sel == 1) begin
      iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv5 = 1'b1; a5 = a[4:0]; b5 = b[4:0];
    end
    @(posedge clk); #1;
  endtask

  // Count CALC cycles to out_valid, optionally stall in DONE, then release
  task automatic wait_done(input string tag, input int exp_res, input int exp_n,
                           input int hold, input bit keep_valid);
    int  n;
    bit  ir_bad;
    n = 0;
    ir_bad = 1'b0;
    while (!ov_m && n <= 300) begin
      @(negedge clk);
      if (!keep_valid) set_valid(cur_sel, 1'b0);
      @(posedge clk); #1;
      n++;
      if (ir_m) ir_bad = 1'b1;
    end
    if (n > 300) begin
      check_val({tag, "_timeout"}, 32'd1, 32'd0);
      return;
    end
    check_val({tag, "_n"}, n, exp_n);
    check_val({tag, "_result"}, res_m, exp_res);
    check_val({tag, "_in_ready_low"}, ir_bad, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_val({tag, "_cycles"}, cyc_m, exp_n);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (cur_sel == 1) begin a8 = a8 ^ 8'h5a; b8 = b8 ^ 8'h33; end
      else              begin a5 = a5 ^ 5'h15; b5 = b5 ^ 5'h0b; end
      @(posedge clk); #1;
      check_val({tag, "_hold_valid"}, ov_m, 32'd1);
      check_val({tag, "_hold_result"}, res_m, exp_res);
    end
    if (hold > 0) begin
      @(negedge clk);
      if (cur_sel == 1) or8 = 1'b1;
      else              or5 = 1'b1;
    end
    @(posedge clk); #1;
    check_val({tag, "_exit_valid"}, ov_m, 32'd0);
    check_val({tag, "_exit_in_ready"}, ir_m, 32'd1);
    check_val({tag, "_exit_result"}, res_m, exp_res);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    iv5 = 1'b0; a5 = 5'd0; b5 = 5'd0; or5 = 1'b1;
    iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_val("rst_in_ready", ir5, 32'd1);
    check_val("rst_out_valid", ov5, 32'd0);
    check_val("rst_busy", busy5, 32'd0);
    check_val("rst_result", res5, 32'd0);
    check_val("rst_result8", res8, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_val("rst_cycles", cyc5, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;

    // (30,10): 30-10, 20-10, 10-10 then zero -> 10, N=4
    start_job(0, 30, 10);
    check_val("t1_busy", busy5, 32'd1);
    wait_done("t1", 10, 4, 0, 1'b0);

    // Back-to-back with in_valid held: second pair ignored until IDLE
    start_job(0, 15, 25);
    b5 = 5'd6;
    wait_done("t2a", 5, 5, 0, 1'b1);
    @(posedge clk); #1;
    check_val("t2_second_capture", busy5, 32'd1);
    iv5 = 1'b0;
    wait_done("t2b", 3, 5, 0, 1'b0);

    // Zero operands and worst case
    start_job(0, 0, 4);
    wait_done("t3_0_4", 4, 1, 0, 1'b0);
    start_job(0, 0, 0);
    wait_done("t3_0_0", 0, 1, 0, 1'b0);
    start_job(0, 7, 7);
    wait_done("t3_7_7", 7, 2, 0, 1'b0);
    start_job(0, 31, 1);
    wait_done("t3_31_1", 1, 32, 0, 1'b0);

    // Stall in DONE for 10 cycles with changing operands
    @(negedge clk); or5 = 1'b0;
    start_job(0, 30, 10);
    wait_done("t4", 10, 4, 10, 1'b0);

    // clear mid-CALC with simultaneous in_valid
    start_job(0, 30, 10);
    @(negedge clk); iv5 = 1'b0;
    @(posedge clk);
    @(negedge clk); clear = 1'b1; iv5 = 1'b1; a5 = 5'd7; b5 = 5'd7;
    @(posedge clk); #1;
    check_val("t5_clr_in_ready", ir5, 32'd1);
    check_val("t5_clr_busy", busy5, 32'd0);
    check_val("t5_clr_out_valid", ov5, 32'd0);
    check_val("t5_clr_result", res5, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_val("t5_clr_cycles", cyc5, 32'd0);
`endif
    @(negedge clk); clear = 1'b0; iv5 = 1'b0;
    @(posedge clk); #1;
    check_val("t5_no_capture", busy5, 32'd0);

    // (9,6): 9-6, 6-3, 3-3 then zero -> 3, N=4
    start_job(0, 9, 6);
    wait_done("t5_9_6", 3, 4, 0, 1'b0);

    // Async reset mid-CALC
    start_job(0, 31, 1);
    @(negedge clk); iv5 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_val("t5_rst_busy", busy5, 32'd0);
    check_val("t5_rst_in_ready", ir5, 32'd1);
    check_val("t5_rst_result", res5, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
    check_val("t5_rst_cycles", cyc5, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;

    // WIDTH=8 instance
    start_job(1, 255, 1);
    wait_done("t6_255_1", 1, 256, 0, 1'b0);
    // 252-198=54; 198->144,90,36; 54-36=18; 36-18=18; 18-18=0 -> 7 subs
    start_job(1, 252, 198);
    wait_done("t6_252_198", 18, 8, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_gcd_engine
